// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH decimation chain.
package prach_pkg;

  localparam int NumChannel     = 64;
  localparam int NumChannelUsed = 48;

  typedef logic [7:0]         prach_chn_t;
  typedef logic signed [15:0] prach_sample_t;

endpackage

// File: rtl/prach_chn_buf.sv
// Single-port per-channel sample buffer with registered read (latency 1).
module prach_chn_buf
  import prach_pkg::*;
#(
  parameter int Depth     = NumChannelUsed,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  prach_sample_t        wdata,
  output prach_sample_t        rdata
);

  prach_sample_t mem_r [Depth];

  // Storage array; no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register; holds its value on write and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 16'sd0;
    end else if (en && !we) begin
      rdata <= mem_r[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/prach_hb3_sched.sv
// Pairs even/odd-frame samples per channel for the third PRACH half-band stage.
// Optional channel-sequence checker: define PRACH_HB3_SCHED_CHK_EN.
module prach_hb3_sched
  import prach_pkg::*;
#(
  parameter int NumChannelUsed = prach_pkg::NumChannelUsed,
  parameter int ChnWidth       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  prach_sample_t       din_dq,
  input  logic                din_dv,
  input  logic [ChnWidth-1:0] din_chn,
  input  logic                sync_in,
  output prach_sample_t       dout_dp1,
  output prach_sample_t       dout_dp2,
  output logic                dout_dv,
  output logic [ChnWidth-1:0] dout_chn,
  output logic                sync_out,
  output logic                err
);

  localparam int AddrWidth = $clog2(NumChannelUsed);
  localparam logic [ChnWidth-1:0] LastChn = ChnWidth'(NumChannelUsed - 1);

  logic                      parity_r;
  logic                      sync_pend_r;
  logic [NumChannelUsed-1:0] pend_r;

  logic [AddrWidth-1:0] addr_s;
  logic                 acc_s;
  logic                 realign_s;
  logic                 phase_s;
  logic                 last_s;
  logic                 wr_s;
  logic                 issue_s;

  // Sample qualification; a realign forces the even phase for its own sample.
  always_comb begin
    addr_s    = din_chn[AddrWidth-1:0];
    acc_s     = din_dv && (din_chn <= LastChn);
    realign_s = acc_s && sync_in && (din_chn == {ChnWidth{1'b0}});
    phase_s   = realign_s ? 1'b0 : parity_r;
    last_s    = (din_chn == LastChn);
    wr_s      = acc_s && !phase_s;
    issue_s   = acc_s && phase_s && pend_r[addr_s];
  end

  prach_chn_buf #(
    .Depth     (NumChannelUsed),
    .AddrWidth (AddrWidth)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_s || issue_s),
    .we    (wr_s),
    .addr  (addr_s),
    .wdata (din_dq),
    .rdata (dout_dp2)
  );

  // Frame parity, held-sample flags and pending sync marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r    <= 1'b0;
      pend_r      <= {NumChannelUsed{1'b0}};
      sync_pend_r <= 1'b0;
    end else begin
      if (acc_s) begin
        parity_r <= last_s ? ~phase_s : phase_s;
        if (realign_s) begin
          pend_r <= {{(NumChannelUsed-1){1'b0}}, 1'b1};
        end else begin
          pend_r[addr_s] <= wr_s;
        end
      end
      if (realign_s) begin
        sync_pend_r <= 1'b1;
      end else if (issue_s) begin
        sync_pend_r <= 1'b0;
      end else begin
        sync_pend_r <= sync_pend_r;
      end
    end
  end

  // Output register; data fields hold between pairs, dv/sync_out pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dp1 <= 16'sd0;
      dout_chn <= {ChnWidth{1'b0}};
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= issue_s;
      sync_out <= issue_s && sync_pend_r;
      if (issue_s) begin
        dout_dp1 <= din_dq;
        dout_chn <= din_chn;
      end
    end
  end

`ifdef PRACH_HB3_SCHED_CHK_EN
  logic [ChnWidth-1:0] exp_chn_r;
  logic                err_r;
  logic                range_err_s;
  logic                seq_err_s;

  // Sequence and range violations.
  always_comb begin
    range_err_s = din_dv && (din_chn > LastChn);
    seq_err_s   = acc_s && !realign_s && (din_chn != exp_chn_r);
  end

  // Expected channel tracks the stream (resyncs after a mismatch); err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_chn_r <= {ChnWidth{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (acc_s) begin
        if (realign_s) begin
          exp_chn_r <= ChnWidth'(1);
        end else if (last_s) begin
          exp_chn_r <= {ChnWidth{1'b0}};
        end else begin
          exp_chn_r <= din_chn + ChnWidth'(1);
        end
      end
      if (range_err_s || seq_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb3_sched.sv
// Directed bench for prach_hb3_sched: framing, gaps, realign, errors, reset.
module tb_prach_hb3_sched;

`ifdef PRACH_HB3_SCHED_CHK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] dp1;
    logic [15:0] dp2;
    logic [7:0]  chn;
    logic        sync;
  } pair_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err;

  int checks = 0;
  int errors = 0;
  pair_t cap_q [$];

  prach_hb3_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_dv === 1'b1) begin
      cap_q.push_back({dout_dp1, dout_dp2, dout_chn, sync_out});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int chn, input int dq, input logic sy);
    din_dv  = 1'b1;
    din_chn = 8'(chn);
    din_dq  = 16'(dq);
    sync_in = sy;
    @(posedge clk);
    #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  // One frame f of channels 0..last (skip < 0 keeps all), data 256*f+chn.
  task automatic send_frame(input int f, input logic sy, input int last, input int skip,
                            input int max_gap);
    for (int c = 0; c <= last; c++) begin
      if (c != skip) begin
        send(c, 256 * f + c, sy && (c == 0));
        if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout_dp1 !== 16'd0) begin errors++; $display("FAIL reset_dp1 got %h want 0000", dout_dp1); end
    checks++; if (dout_dp2 !== 16'd0) begin errors++; $display("FAIL reset_dp2 got %h want 0000", dout_dp2); end
    checks++; if (dout_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dout_dv); end
    checks++; if (dout_chn !== 8'd0) begin errors++; $display("FAIL reset_chn got %0d want 0", dout_chn); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", sync_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    idle(2);
  endtask

  // Four frames starting at frame-0 realign; gaps optional.
  task automatic test_frames(input int max_gap);
    pair_t got;
    pair_t exp;
    cap_q.delete();
    for (int f = 0; f < 4; f++) send_frame(f, (f == 0), 47, -1, max_gap);
    idle(3);
    checks++;
    if (cap_q.size() != 96) begin
      errors++; $display("FAIL frames_count gap=%0d got %0d want 96", max_gap, cap_q.size());
    end
    for (int i = 0; i < 96; i++) begin
      got = '0;
      if (i < cap_q.size()) got = cap_q[i];
      exp.dp1  = 16'((i < 48) ? (256 + i) : (768 + i - 48));
      exp.dp2  = 16'((i < 48) ? i : (512 + i - 48));
      exp.chn  = 8'(i % 48);
      exp.sync = (i == 0);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL frames_pair gap=%0d idx %0d got %h want %h", max_gap, i, got, exp);
      end
    end
    got = '0;
    if (cap_q.size() > 5) got = cap_q[5];
    checks++;
    if (got.dp1 !== 16'd261 || got.dp2 !== 16'd5) begin
      errors++; $display("FAIL frames_ch5 got dp1=%0d dp2=%0d want dp1=261 dp2=5", got.dp1, got.dp2);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL frames_err gap=%0d got %b want 0", max_gap, err); end
  endtask

  task automatic test_midsync;
    pair_t got;
    pair_t exp;
    send_frame(4, 1'b0, 47, -1, 0);
    cap_q.delete();
    send_frame(5, 1'b0, 20, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 21) begin errors++; $display("FAIL midsync_partial got %0d want 21", cap_q.size()); end
    cap_q.delete();
    send_frame(6, 1'b1, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL midsync_realign_frame got %0d want 0", cap_q.size()); end
    send_frame(7, 1'b0, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 48) begin errors++; $display("FAIL midsync_count got %0d want 48", cap_q.size()); end
    for (int c = 0; c < 48; c++) begin
      got = '0;
      if (c < cap_q.size()) got = cap_q[c];
      exp = {16'(7 * 256 + c), 16'(6 * 256 + c), 8'(c), (c == 0)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL midsync_pair ch %0d got %h want %h", c, got, exp); end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL midsync_err got %b want 0", err); end
  endtask

  task automatic test_out_of_range;
    pair_t got;
    pair_t exp;
    cap_q.delete();
    din_dv  = 1'b1;
    din_chn = 8'd50;
    din_dq  = 16'h7fff;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL oor_err_early got %b want 0", err); end
    @(posedge clk);
    #1;
    din_dv = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== ChkEn) begin errors++; $display("FAIL oor_err_rise got %b want %b", err, ChkEn); end
    checks++;
    if (dout_dv !== 1'b0) begin errors++; $display("FAIL oor_dv got %b want 0", dout_dv); end
    @(posedge clk);
    #1;
    idle(3);
    checks++;
    if (err !== ChkEn) begin errors++; $display("FAIL oor_err_sticky got %b want %b", err, ChkEn); end
    send_frame(8, 1'b0, 47, -1, 0);
    send_frame(9, 1'b0, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 48) begin errors++; $display("FAIL oor_after_count got %0d want 48", cap_q.size()); end
    for (int c = 0; c < 48; c++) begin
      got = '0;
      if (c < cap_q.size()) got = cap_q[c];
      exp = {16'(9 * 256 + c), 16'(8 * 256 + c), 8'(c), 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL oor_after_pair ch %0d got %h want %h", c, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    pair_t got;
    pair_t exp;
    send_frame(10, 1'b0, 47, -1, 0);
    send_frame(11, 1'b0, 20, -1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dout_dp1 !== 16'd0) begin errors++; $display("FAIL rstmid_dp1 got %h want 0000", dout_dp1); end
    checks++; if (dout_dp2 !== 16'd0) begin errors++; $display("FAIL rstmid_dp2 got %h want 0000", dout_dp2); end
    checks++; if (dout_dv !== 1'b0) begin errors++; $display("FAIL rstmid_dv got %b want 0", dout_dv); end
    checks++; if (dout_chn !== 8'd0) begin errors++; $display("FAIL rstmid_chn got %0d want 0", dout_chn); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL rstmid_sync got %b want 0", sync_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_q.delete();
    send_frame(12, 1'b0, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL rstmid_first_frame got %0d want 0", cap_q.size()); end
    send_frame(13, 1'b0, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 48) begin errors++; $display("FAIL rstmid_count got %0d want 48", cap_q.size()); end
    for (int c = 0; c < 48; c++) begin
      got = '0;
      if (c < cap_q.size()) got = cap_q[c];
      exp = {16'(13 * 256 + c), 16'(12 * 256 + c), 8'(c), 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rstmid_pair ch %0d got %h want %h", c, got, exp); end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err_after got %b want 0", err); end
  endtask

  task automatic test_skip;
    pair_t got;
    pair_t exp;
    int    c;
    cap_q.delete();
    send_frame(14, 1'b0, 47, 10, 0);
    send_frame(15, 1'b0, 47, -1, 0);
    idle(2);
    checks++;
    if (cap_q.size() != 47) begin errors++; $display("FAIL skip_count got %0d want 47", cap_q.size()); end
    for (int i = 0; i < 47; i++) begin
      c = (i < 10) ? i : i + 1;
      got = '0;
      if (i < cap_q.size()) got = cap_q[i];
      exp = {16'(15 * 256 + c), 16'(14 * 256 + c), 8'(c), 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL skip_pair idx %0d got %h want %h", i, got, exp); end
    end
    checks++;
    if (err !== ChkEn) begin errors++; $display("FAIL skip_err got %b want %b", err, ChkEn); end
  endtask

  initial begin
    rst_n   = 1'b1;
    din_dq  = 16'd0;
    din_dv  = 1'b0;
    din_chn = 8'd0;
    sync_in = 1'b0;
    #2;
    test_reset();
    test_frames(0);
    test_frames(20);
    test_midsync();
    test_out_of_range();
    test_reset_mid();
    test_skip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
